// File: rtl/control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// decoded instruction classes and datapath mux select values.
package control_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_JMI   = 6'b110000;
   localparam logic [5:0] OP_SAI   = 6'b110001;
   localparam logic [5:0] OP_PMC   = 6'b110010;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_ALU_WB,
      S_MEM_ADDR,
      S_MEM_READ,
      S_LOAD_WB,
      S_MEM_WRITE,
      S_BRANCH,
      S_JUMP,
      S_JMI_READ,
      S_SAI_WRITE,
      S_SAI_WB,
      S_PMC_COPY
   } state_e;

   typedef enum logic [3:0] {
      CL_RTYPE,
      CL_ADDI,
      CL_ANDI,
      CL_LW,
      CL_SW,
      CL_BEQ,
      CL_J,
      CL_JMI,
      CL_SAI,
      CL_PMC,
      CL_ILLEGAL
   } instr_class_e;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_AND   = 2'b11;

   localparam logic [1:0] ALU_B_RT       = 2'b00;
   localparam logic [1:0] ALU_B_FOUR     = 2'b01;
   localparam logic [1:0] ALU_B_IMM      = 2'b10;
   localparam logic [1:0] ALU_B_IMM_SHL2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU     = 2'b00;
   localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP    = 2'b10;
   localparam logic [1:0] PC_SRC_MEM     = 2'b11;

   localparam logic [1:0] REG_DST_RT = 2'b00;
   localparam logic [1:0] REG_DST_RD = 2'b01;
   localparam logic [1:0] REG_DST_RS = 2'b10;

   // States that wait on memory_ready and are covered by the wait timer.
   function automatic logic is_mem_state(state_e s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE) ||
             (s == S_JMI_READ) || (s == S_SAI_WRITE) || (s == S_PMC_COPY);
   endfunction

endpackage

// File: rtl/memory_wait_timer.sv
// Memory wait timer: down-counter reloaded with MEM_TIMEOUT on clear and
// terminal-count compare; MEM_TIMEOUT = 0 disables expiry entirely.
module memory_wait_timer #(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [W-1:0] LOAD_VALUE = W'(MEM_TIMEOUT);

   logic [W-1:0] remaining;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         remaining <= LOAD_VALUE;
      end else if (count_en && (remaining != '0)) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign expired = (MEM_TIMEOUT != 0) && (remaining == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences each instruction over shared memory and
// ALU, with memory handshake, optional timeout, stall, illegal trap and retire count.
module multicycle_control_unit
   import control_unit_pkg::*;
#(
   parameter int OPCODE_WIDTH  = 6,
   parameter bit ENABLE_CUSTOM = 1'b1,
   parameter int MEM_TIMEOUT   = 0,
   parameter int COUNT_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OPCODE_WIDTH-1:0] op_code,
   input  logic                    memory_ready,
   input  logic                    stall,
   output logic                    pc_write,
   output logic                    ir_write,
   output logic                    reg_write,
   output logic                    memory_read,
   output logic                    memory_write,
   output logic                    branch,
   output logic                    memory_to_register,
   output logic                    alu_source_a,
   output logic [1:0]              alu_source_b,
   output logic [1:0]              alu_op,
   output logic [1:0]              register_destination,
   output logic [1:0]              pc_source,
   output logic                    memory_write_source,
   output logic                    memory_read_source,
   output logic                    instruction_done,
   output logic                    illegal_opcode,
   output logic                    bus_error,
   output logic [COUNT_WIDTH-1:0]  retired_count
);

   // state       | meaning
   // S_FETCH     | read instruction, PC += 4 on ready
   // S_DECODE    | classify opcode, precompute branch target
   // S_EXECUTE   | ALU op for R-type / addi / andi
   // S_ALU_WB    | write ALU result to register file
   // S_MEM_ADDR  | compute effective address
   // S_MEM_READ  | load data read, wait for ready
   // S_LOAD_WB   | write loaded data to register file
   // S_MEM_WRITE | store, wait for ready
   // S_BRANCH    | compare and conditional PC write
   // S_JUMP      | PC <= jump target
   // S_JMI_READ  | PC <= memory data on ready
   // S_SAI_WRITE | store half of store-and-increment
   // S_SAI_WB    | write incremented base to rs
   // S_PMC_COPY  | program memory read+write copy

   state_e       state, state_next;
   instr_class_e live_class, op_class;
   logic         mem_state, expired, timeout, count_en, timer_clear;

   always_comb begin
      live_class = CL_ILLEGAL;
      if (op_code == OPCODE_WIDTH'(OP_RTYPE))                      live_class = CL_RTYPE;
      else if (op_code == OPCODE_WIDTH'(OP_ADDI))                  live_class = CL_ADDI;
      else if (op_code == OPCODE_WIDTH'(OP_ANDI))                  live_class = CL_ANDI;
      else if (op_code == OPCODE_WIDTH'(OP_LW))                    live_class = CL_LW;
      else if (op_code == OPCODE_WIDTH'(OP_SW))                    live_class = CL_SW;
      else if (op_code == OPCODE_WIDTH'(OP_BEQ))                   live_class = CL_BEQ;
      else if (op_code == OPCODE_WIDTH'(OP_J))                     live_class = CL_J;
      else if (ENABLE_CUSTOM && op_code == OPCODE_WIDTH'(OP_JMI))  live_class = CL_JMI;
      else if (ENABLE_CUSTOM && op_code == OPCODE_WIDTH'(OP_SAI))  live_class = CL_SAI;
      else if (ENABLE_CUSTOM && op_code == OPCODE_WIDTH'(OP_PMC))  live_class = CL_PMC;
   end

   assign mem_state   = is_mem_state(state);
   assign timeout     = mem_state && !memory_ready && !stall && expired;
   assign count_en    = mem_state && !memory_ready && !stall && !expired;
   assign timer_clear = (state_next != state) || timeout;

   memory_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .count_en (count_en),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FETCH;
         op_class      <= CL_ILLEGAL;
         retired_count <= '0;
      end else begin
         state <= state_next;
         if (state == S_DECODE) op_class <= live_class;
         if (instruction_done) retired_count <= retired_count + 1'b1;
      end
   end

   always_comb begin
      state_next           = state;
      pc_write             = 1'b0;
      ir_write             = 1'b0;
      reg_write            = 1'b0;
      memory_read          = 1'b0;
      memory_write         = 1'b0;
      branch               = 1'b0;
      memory_to_register   = 1'b0;
      alu_source_a         = 1'b0;
      alu_source_b         = ALU_B_RT;
      alu_op               = ALU_OP_ADD;
      register_destination = REG_DST_RT;
      pc_source            = PC_SRC_ALU;
      memory_write_source  = 1'b0;
      memory_read_source   = 1'b0;
      instruction_done     = 1'b0;
      illegal_opcode       = 1'b0;
      bus_error            = 1'b0;

      // All defaults are zero, so skipping the decode holds every output low in reset.
      if (!reset) begin
         case (state)
            S_FETCH: begin
               memory_read  = 1'b1;
               alu_source_b = ALU_B_FOUR;
               ir_write     = memory_ready;
               pc_write     = memory_ready;
               if (memory_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
               alu_source_b = ALU_B_IMM_SHL2;
               case (live_class)
                  CL_RTYPE, CL_ADDI, CL_ANDI:        state_next = S_EXECUTE;
                  CL_LW, CL_SW, CL_JMI, CL_SAI, CL_PMC: state_next = S_MEM_ADDR;
                  CL_BEQ:                            state_next = S_BRANCH;
                  CL_J:                              state_next = S_JUMP;
                  default: begin
                     illegal_opcode = 1'b1;
                     state_next     = S_FETCH;
                  end
               endcase
            end
            S_EXECUTE: begin
               alu_source_a = 1'b1;
               if (op_class == CL_RTYPE) alu_op = ALU_OP_FUNCT;
               if (op_class == CL_ADDI || op_class == CL_ANDI) alu_source_b = ALU_B_IMM;
               if (op_class == CL_ANDI) alu_op = ALU_OP_AND;
               state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
               reg_write            = 1'b1;
               register_destination = (op_class == CL_RTYPE) ? REG_DST_RD : REG_DST_RT;
               instruction_done     = 1'b1;
            end
            S_MEM_ADDR: begin
               alu_source_a = 1'b1;
               alu_source_b = ALU_B_IMM;
               case (op_class)
                  CL_LW:   state_next = S_MEM_READ;
                  CL_JMI:  state_next = S_JMI_READ;
                  CL_SW:   state_next = S_MEM_WRITE;
                  CL_SAI:  state_next = S_SAI_WRITE;
                  CL_PMC:  state_next = S_PMC_COPY;
                  default: state_next = S_FETCH;
               endcase
            end
            S_MEM_READ: begin
               memory_read = 1'b1;
               if (memory_ready) state_next = S_LOAD_WB;
            end
            S_LOAD_WB: begin
               reg_write          = 1'b1;
               memory_to_register = 1'b1;
               instruction_done   = 1'b1;
            end
            S_MEM_WRITE: begin
               memory_write     = 1'b1;
               instruction_done = memory_ready;
            end
            S_BRANCH: begin
               alu_source_a     = 1'b1;
               alu_op           = ALU_OP_SUB;
               branch           = 1'b1;
               pc_source        = PC_SRC_ALU_OUT;
               instruction_done = 1'b1;
            end
            S_JUMP: begin
               pc_write         = 1'b1;
               pc_source        = PC_SRC_JUMP;
               instruction_done = 1'b1;
            end
            S_JMI_READ: begin
               memory_read      = 1'b1;
               pc_source        = PC_SRC_MEM;
               pc_write         = memory_ready;
               instruction_done = memory_ready;
            end
            S_SAI_WRITE: begin
               memory_write = 1'b1;
               if (memory_ready) state_next = S_SAI_WB;
            end
            S_SAI_WB: begin
               reg_write            = 1'b1;
               register_destination = REG_DST_RS;
               instruction_done     = 1'b1;
            end
            S_PMC_COPY: begin
               memory_read         = 1'b1;
               memory_write        = 1'b1;
               memory_read_source  = 1'b1;
               memory_write_source = 1'b1;
               instruction_done    = memory_ready;
            end
            default: state_next = S_FETCH;
         endcase

         if (instruction_done) state_next = S_FETCH;

         // A timed-out access is abandoned: no writes, no retire, refetch.
         if (timeout) begin
            bus_error        = 1'b1;
            pc_write         = 1'b0;
            ir_write         = 1'b0;
            reg_write        = 1'b0;
            memory_write     = 1'b0;
            branch           = 1'b0;
            instruction_done = 1'b0;
            state_next       = S_FETCH;
         end

         // Stall freezes progress; reads and mux selects stay as decoded.
         if (stall) begin
            pc_write         = 1'b0;
            ir_write         = 1'b0;
            reg_write        = 1'b0;
            memory_write     = 1'b0;
            branch           = 1'b0;
            instruction_done = 1'b0;
            illegal_opcode   = 1'b0;
            state_next       = state;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: three configurations share the
// stimulus and are each checked against an instruction-step reference model.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       memory_read;
      logic       memory_write;
      logic       branch;
      logic       memory_to_register;
      logic       alu_source_a;
      logic [1:0] alu_source_b;
      logic [1:0] alu_op;
      logic [1:0] register_destination;
      logic [1:0] pc_source;
      logic       memory_write_source;
      logic       memory_read_source;
      logic       instruction_done;
      logic       illegal_opcode;
      logic       bus_error;
   } ctl_t;

   typedef struct {
      ctl_t c;
      bit   mem;
      bit   gated;
      bit   last;
   } step_t;

   localparam int K_R = 0, K_ADDI = 1, K_ANDI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                  K_J = 6, K_JMI = 7, K_SAI = 8, K_PMC = 9, K_ILL = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  op_code;
   logic        memory_ready;
   logic        stall;
   ctl_t        obs [3];
   logic [31:0] cnt [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic       pcw, irw, rw, mr, mw, br, m2r, asa, mws, mrs, done, ill, berr;
      logic [1:0] asb, aop, rd, pcs;

      multicycle_control_unit #(
         .OPCODE_WIDTH  (6),
         .ENABLE_CUSTOM ((g == 2) ? 1'b0 : 1'b1),
         .MEM_TIMEOUT   ((g == 1) ? 2 : ((g == 2) ? 3 : 0)),
         .COUNT_WIDTH   (32)
      ) u_dut (
         .clk                  (clk),
         .reset                (reset),
         .op_code              (op_code),
         .memory_ready         (memory_ready),
         .stall                (stall),
         .pc_write             (pcw),
         .ir_write             (irw),
         .reg_write            (rw),
         .memory_read          (mr),
         .memory_write         (mw),
         .branch               (br),
         .memory_to_register   (m2r),
         .alu_source_a         (asa),
         .alu_source_b         (asb),
         .alu_op               (aop),
         .register_destination (rd),
         .pc_source            (pcs),
         .memory_write_source  (mws),
         .memory_read_source   (mrs),
         .instruction_done     (done),
         .illegal_opcode       (ill),
         .bus_error            (berr),
         .retired_count        (cnt[g])
      );

      assign obs[g] = {pcw, irw, rw, mr, mw, br, m2r, asa, asb, aop, rd, pcs, mws, mrs, done, ill, berr};
   end

   bit          en_c [3] = '{1'b1, 1'b1, 1'b0};
   int          tmax [3] = '{0, 2, 3};
   step_t       plan [3][5];
   int          pos  [3];
   int          wcnt [3];
   logic [31:0] ret  [3];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic int cls_of(input logic [5:0] op, input bit en);
      case (op)
         6'b000000: return K_R;
         6'b001000: return K_ADDI;
         6'b001100: return K_ANDI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         6'b110000: return en ? K_JMI : K_ILL;
         6'b110001: return en ? K_SAI : K_ILL;
         6'b110010: return en ? K_PMC : K_ILL;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic step_t blank(input bit mem, input bit last);
      step_t s;
      s.c = '0;
      s.mem = mem;
      s.gated = 1'b0;
      s.last = last;
      return s;
   endfunction

   // Steps that follow DECODE for an instruction of class k.
   task automatic build(input int i, input int k);
      step_t s;
      if (k == K_R || k == K_ADDI || k == K_ANDI) begin
         s = blank(0, 0);
         s.c.alu_source_a = 1'b1;
         if (k == K_R) s.c.alu_op = 2'b10;
         if (k != K_R) s.c.alu_source_b = 2'b10;
         if (k == K_ANDI) s.c.alu_op = 2'b11;
         plan[i][2] = s;
         s = blank(0, 1);
         s.c.reg_write = 1'b1;
         s.c.register_destination = (k == K_R) ? 2'b01 : 2'b00;
         plan[i][3] = s;
      end else if (k == K_BEQ) begin
         s = blank(0, 1);
         s.c.alu_source_a = 1'b1;
         s.c.alu_op = 2'b01;
         s.c.branch = 1'b1;
         s.c.pc_source = 2'b01;
         plan[i][2] = s;
      end else if (k == K_J) begin
         s = blank(0, 1);
         s.c.pc_write = 1'b1;
         s.c.pc_source = 2'b10;
         plan[i][2] = s;
      end else if (k != K_ILL) begin
         s = blank(0, 0);
         s.c.alu_source_a = 1'b1;
         s.c.alu_source_b = 2'b10;
         plan[i][2] = s;
         s = blank(1, (k != K_LW && k != K_SAI));
         case (k)
            K_LW:  s.c.memory_read = 1'b1;
            K_SW:  s.c.memory_write = 1'b1;
            K_SAI: s.c.memory_write = 1'b1;
            K_JMI: begin
               s.c.memory_read = 1'b1;
               s.c.pc_source = 2'b11;
               s.c.pc_write = 1'b1;
               s.gated = 1'b1;
            end
            default: begin
               s.c.memory_read = 1'b1;
               s.c.memory_write = 1'b1;
               s.c.memory_read_source = 1'b1;
               s.c.memory_write_source = 1'b1;
            end
         endcase
         plan[i][3] = s;
         s = blank(0, 1);
         s.c.reg_write = 1'b1;
         if (k == K_LW) s.c.memory_to_register = 1'b1;
         if (k == K_SAI) s.c.register_destination = 2'b10;
         plan[i][4] = s;
      end
   endtask

   task automatic eval_dut(input int i);
      step_t s;
      ctl_t  e;
      bit    tmo, adv, dec;
      int    k;
      k   = cls_of(op_code, en_c[i]);
      s   = plan[i][pos[i]];
      dec = (pos[i] == 1);
      tmo = s.mem && !memory_ready && !stall && (tmax[i] != 0) && (wcnt[i] == tmax[i]);
      adv = !stall && !tmo && (!s.mem || memory_ready);
      e = s.c;
      if (s.gated && !memory_ready) begin
         e.pc_write = 1'b0;
         e.ir_write = 1'b0;
      end
      if (adv && dec && k == K_ILL) e.illegal_opcode = 1'b1;
      if (adv && s.last) e.instruction_done = 1'b1;
      if (tmo) e.bus_error = 1'b1;
      if (tmo || stall) begin
         e.pc_write = 1'b0;
         e.ir_write = 1'b0;
         e.reg_write = 1'b0;
         e.memory_write = 1'b0;
         e.branch = 1'b0;
      end
      if (reset) e = '0;
      check_value($sformatf("ctl%0d", i), 32'(obs[i]), 32'(e));
      check_value($sformatf("retired%0d", i), cnt[i], ret[i]);

      if (reset) begin
         pos[i] = 0;
         wcnt[i] = 0;
         ret[i] = '0;
      end else if (tmo) begin
         pos[i] = 0;
         wcnt[i] = 0;
      end else if (adv) begin
         wcnt[i] = 0;
         if (s.last) begin
            ret[i] = ret[i] + 1;
            pos[i] = 0;
         end else if (dec) begin
            build(i, k);
            pos[i] = (k == K_ILL) ? 0 : 2;
         end else begin
            pos[i] = pos[i] + 1;
         end
      end else if (s.mem && !memory_ready && !stall) begin
         wcnt[i] = wcnt[i] + 1;
      end
   endtask

   task automatic cycle(input logic r, input logic [5:0] op, input logic rdy, input logic st);
      reset = r;
      op_code = op;
      memory_ready = rdy;
      stall = st;
      @(negedge clk);
      for (int i = 0; i < 3; i++) eval_dut(i);
      @(posedge clk);
      #1;
   endtask

   logic [5:0] ops [12] = '{6'b000000, 6'b001000, 6'b001100, 6'b100011, 6'b101011, 6'b000100,
                            6'b000010, 6'b110000, 6'b110001, 6'b110010, 6'b111111, 6'b000000};

   initial begin
      int         mode;
      int         idx;
      logic       rdy;
      logic [5:0] op;

      for (int i = 0; i < 3; i++) begin
         plan[i][0] = blank(1, 0);
         plan[i][0].gated = 1'b1;
         plan[i][0].c.memory_read = 1'b1;
         plan[i][0].c.alu_source_b = 2'b01;
         plan[i][0].c.pc_write = 1'b1;
         plan[i][0].c.ir_write = 1'b1;
         plan[i][1] = blank(0, 0);
         plan[i][1].c.alu_source_b = 2'b11;
         pos[i] = 0;
         wcnt[i] = 0;
         ret[i] = '0;
      end

      cycle(1'b1, 6'b000000, 1'b1, 1'b0);
      cycle(1'b1, 6'b000000, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) cycle(1'b0, 6'b000000, 1'b1, 1'b0);
      check_value("add_retired", cnt[0], 32'd1);

      // sw with memory stuck low; the MEM_TIMEOUT=2 instance must abort it.
      cycle(1'b0, 6'b101011, 1'b1, 1'b0);
      cycle(1'b0, 6'b101011, 1'b1, 1'b0);
      cycle(1'b0, 6'b101011, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) cycle(1'b0, 6'b101011, 1'b0, 1'b0);
      check_value("sw_timeout_retired", cnt[1], 32'd1);

      // PMC then JMI, with a reset landing in the middle of JMI.
      cycle(1'b1, 6'b000000, 1'b1, 1'b0);
      for (int n = 0; n < 4; n++) cycle(1'b0, 6'b110010, 1'b1, 1'b0);
      for (int n = 0; n < 3; n++) cycle(1'b0, 6'b110000, 1'b1, 1'b0);
      cycle(1'b1, 6'b110000, 1'b1, 1'b0);

      mode = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 16 == 0) mode = $urandom_range(0, 2);
         if (mode == 0) rdy = 1'b1;
         else if (mode == 1) rdy = ($urandom_range(0, 9) < 6);
         else rdy = ($urandom_range(0, 9) < 2);
         idx = $urandom_range(0, 11);
         op = (idx == 11) ? 6'($urandom) : ops[idx];
         cycle(($urandom_range(0, 199) == 0), op, rdy, ($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
